// File: rtl/eth_frame_tx_if.sv
// Bundle of the frame-request, payload-stream and line-side signals of eth_frame_tx.
// master: frame source / line observer. slave: the transmitter itself.
interface eth_frame_tx_if;
  logic        start;
  logic [47:0] dest_addr;
  logic [47:0] src_addr;
  logic [15:0] eth_type;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_last;
  logic        pl_ready;
  logic [7:0]  tx_out;
  logic        tx_en;
  logic        tx_done;
  logic        tx_err;
  logic        busy;

  modport master (
    output start, dest_addr, src_addr, eth_type, pl_data, pl_valid, pl_last,
    input  pl_ready, tx_out, tx_en, tx_done, tx_err, busy
  );

  modport slave (
    input  start, dest_addr, src_addr, eth_type, pl_data, pl_valid, pl_last,
    output pl_ready, tx_out, tx_en, tx_done, tx_err, busy
  );
endinterface

// File: rtl/eth_frame_tx.sv
// Ethernet frame transmitter: preamble, SFD, header, streamed payload, optional
// zero padding to 46 bytes, CRC-32 FCS, then a forced inter-frame gap.
// Optional feature: define ETH_TX_PAD_EN to pad short payloads to 46 bytes.
// The state register names the byte currently on the line; every output is registered.
module eth_frame_tx #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MAX_PAYLOAD  = 1500,
  parameter int unsigned IFG_CYCLES   = 12
) (
  input  logic          clk,
  input  logic          rst,
  eth_frame_tx_if.slave bus
);
  localparam int unsigned CntW     = $clog2(MAX_PAYLOAD + 2);
  localparam int unsigned MinFrame = 46;

  typedef enum logic [3:0] {
    StIdle, StPreamble, StSfd, StDest, StSrc, StType, StPayload,
`ifdef ETH_TX_PAD_EN
    StPad,
`endif
    StFcs, StIfg
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      step_q, step_d;
  logic [CntW-1:0] pl_cnt_q, pl_cnt_d, pl_cnt_inc;
  logic [31:0]     crc_q, crc_d;
  logic [111:0]    hdr_q, hdr_d;
  logic [7:0]      tx_out_q, tx_out_d;
  logic            tx_en_q, tx_en_d, tx_done_q, tx_done_d, tx_err_q, tx_err_d;
  logic            busy_q, busy_d, pl_ready_q, pl_ready_d;
  logic            start_ok, accept, abort;
  logic [3:0]      hdr_idx;
  logic [111:0]    hdr_sh;
  logic [31:0]     fcs_sh;

  function automatic logic [31:0] crc32_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  // Handshake decode: an offered slot either takes a byte or aborts (underrun/overflow).
  always_comb begin
    start_ok   = (state_q == StIdle) && bus.start && !busy_q;
    accept     = pl_ready_q && bus.pl_valid && (pl_cnt_q != CntW'(MAX_PAYLOAD));
    abort      = pl_ready_q && !accept;
    pl_cnt_inc = (pl_cnt_q == '1) ? pl_cnt_q : pl_cnt_q + 1'b1;
  end

  // State register plus registered outputs, CRC, counters and latched header.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      step_q     <= '0;
      pl_cnt_q   <= '0;
      crc_q      <= '0;
      hdr_q      <= '0;
      tx_out_q   <= '0;
      tx_en_q    <= 1'b0;
      tx_done_q  <= 1'b0;
      tx_err_q   <= 1'b0;
      busy_q     <= 1'b0;
      pl_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      pl_cnt_q   <= pl_cnt_d;
      crc_q      <= crc_d;
      hdr_q      <= hdr_d;
      tx_out_q   <= tx_out_d;
      tx_en_q    <= tx_en_d;
      tx_done_q  <= tx_done_d;
      tx_err_q   <= tx_err_d;
      busy_q     <= busy_d;
      pl_ready_q <= pl_ready_d;
    end
  end

  // Next-state logic; an abort counts its own error cycle as the first gap cycle.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    pl_cnt_d = pl_cnt_q;
    hdr_d    = hdr_q;
    if (abort) begin
      state_d = (IFG_CYCLES == 0) ? StIdle : StIfg;
      step_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            state_d  = StPreamble;
            step_d   = '0;
            pl_cnt_d = '0;
            hdr_d    = {bus.dest_addr, bus.src_addr, bus.eth_type};
          end
        end
        StPreamble: begin
          if (step_q == 8'(PREAMBLE_LEN - 1)) begin
            state_d = StSfd;
            step_d  = '0;
          end else begin
            step_d = step_q + 8'd1;
          end
        end
        StSfd: begin
          state_d = StDest;
          step_d  = '0;
        end
        StDest, StSrc: begin
          if (step_q == 8'd5) begin
            state_d = (state_q == StDest) ? StSrc : StType;
            step_d  = '0;
          end else begin
            step_d = step_q + 8'd1;
          end
        end
        StType: begin
          if (step_q == 8'd0) begin
            step_d = 8'd1;
          end else if (accept) begin
            state_d  = StPayload;
            pl_cnt_d = pl_cnt_inc;
          end
        end
        StPayload: begin
          if (accept) begin
            pl_cnt_d = pl_cnt_inc;
          end else begin
`ifdef ETH_TX_PAD_EN
            if (pl_cnt_q < CntW'(MinFrame)) begin
              state_d  = StPad;
              pl_cnt_d = pl_cnt_inc;
            end else begin
              state_d = StFcs;
              step_d  = '0;
            end
`else
            state_d = StFcs;
            step_d  = '0;
`endif
          end
        end
`ifdef ETH_TX_PAD_EN
        StPad: begin
          if (pl_cnt_q == CntW'(MinFrame)) begin
            state_d = StFcs;
            step_d  = '0;
          end else begin
            pl_cnt_d = pl_cnt_inc;
          end
        end
`endif
        StFcs: begin
          if (step_q == 8'd3) begin
            state_d = (IFG_CYCLES == 0) ? StIdle : StIfg;
            step_d  = '0;
          end else begin
            step_d = step_q + 8'd1;
          end
        end
        StIfg: begin
          if (step_q == 8'(IFG_CYCLES - 1)) state_d = StIdle;
          else                              step_d  = step_q + 8'd1;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic: the byte and strobes for the state being entered.
  always_comb begin
    tx_out_d   = 8'h00;
    tx_en_d    = 1'b0;
    tx_done_d  = 1'b0;
    tx_err_d   = abort;
    busy_d     = (state_d != StIdle);
    pl_ready_d = 1'b0;
    crc_d      = crc_q;
    unique case (state_d)
      StDest:  hdr_idx = step_d[3:0];
      StSrc:   hdr_idx = step_d[3:0] + 4'd6;
      default: hdr_idx = step_d[3:0] + 4'd12;
    endcase
    hdr_sh = hdr_d << {hdr_idx, 3'b000};
    fcs_sh = (~crc_q) >> {step_d[1:0], 3'b000};
    case (state_d)
      StPreamble: begin
        tx_out_d = 8'h55;
        tx_en_d  = 1'b1;
        crc_d    = 32'hFFFF_FFFF;
      end
      StSfd: begin
        tx_out_d = 8'hD5;
        tx_en_d  = 1'b1;
      end
      StDest, StSrc, StType: begin
        tx_out_d   = hdr_sh[111:104];
        tx_en_d    = 1'b1;
        crc_d      = crc32_step(crc_q, hdr_sh[111:104]);
        pl_ready_d = (state_d == StType) && (step_d == 8'd1);
      end
      StPayload: begin
        tx_out_d   = bus.pl_data;
        tx_en_d    = 1'b1;
        crc_d      = crc32_step(crc_q, bus.pl_data);
        pl_ready_d = !bus.pl_last;
      end
`ifdef ETH_TX_PAD_EN
      StPad: begin
        tx_en_d = 1'b1;
        crc_d   = crc32_step(crc_q, 8'h00);
      end
`endif
      StFcs: begin
        tx_out_d  = fcs_sh[7:0];
        tx_en_d   = 1'b1;
        tx_done_d = (step_d == 8'd3);
      end
      default: ;
    endcase
  end

  assign bus.tx_out   = tx_out_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_done  = tx_done_q;
  assign bus.tx_err   = tx_err_q;
  assign bus.busy     = busy_q;
  assign bus.pl_ready = pl_ready_q;
endmodule

// File: tb/tb_eth_frame_tx.sv
// Bench for eth_frame_tx: table of frame vectors driven through a scoreboard of
// expected line bytes, plus hand-written reset-truncation and start-during-gap sequences.
module tb_eth_frame_tx;
  localparam int unsigned PreLen = 7;
  localparam int unsigned MaxPl  = 64;
  localparam int unsigned Ifg    = 12;
`ifdef ETH_TX_PAD_EN
  localparam int Tot1  = 72;
  localparam int Tot20 = 72;
`else
  localparam int Tot1  = 27;
  localparam int Tot20 = 46;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  eth_frame_tx_if bus();

  eth_frame_tx #(
    .PREAMBLE_LEN(PreLen),
    .MAX_PAYLOAD (MaxPl),
    .IFG_CYCLES  (Ifg)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int         len;
    bit         last;
    logic [7:0] seed;
    int         total;
    bit         done;
    bit         err;
  } vec_t;

  vec_t       vecs[7];
  int         checks = 0;
  int         errors = 0;
  int         cur_case = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  bit         mon_en = 1'b1;
  bit         busy_prev = 1'b0;
  int         en_cycles = 0, done_cnt = 0, err_cnt = 0;
  int         cyc = 0, done_cyc = 0, err_cyc = 0, fall_cyc = 0, en_at_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s case %0d: got %0h, expected %0h", name, cur_case, act, req);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Scoreboard consumer and line observer, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.tx_en) en_cycles++;
    if (bus.tx_done) begin
      done_cnt++;
      done_cyc   = cyc;
      en_at_done = en_cycles;
    end
    if (bus.tx_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (busy_prev && !bus.busy) fall_cyc = cyc;
    busy_prev = bus.busy;
    if (mon_en) begin
      if (bus.tx_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte case %0d: got %0h, expected no byte", cur_case,
                   bus.tx_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("tx_out", 32'(bus.tx_out), 32'(mon_exp));
        end
        if (bus.tx_done) check("done_on_last_byte", exp_q.size(), 0);
      end else begin
        check("idle_out_zero", 32'(bus.tx_out), 0);
        if (bus.tx_done) check("done_without_en", 32'(bus.tx_en), 1);
      end
      if (bus.tx_err) check("err_en_low", 32'(bus.tx_en), 0);
    end
  end

  task automatic push_expect(input int len, input bit last, input logic [7:0] seed,
                             input logic [111:0] hdr);
    logic [31:0]  crc;
    logic [111:0] h;
    logic [7:0]   b;
    int           n;
    crc = 32'hFFFF_FFFF;
    h   = hdr;
    for (int i = 0; i < int'(PreLen); i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int j = 0; j < 14; j++) begin
      b = h[111:104];
      exp_q.push_back(b);
      crc = crc_byte(crc, b);
      h   = h << 8;
    end
    n = (!last && len > int'(MaxPl)) ? int'(MaxPl) : len;
    for (int i = 0; i < n; i++) begin
      b = seed + 8'(i);
      exp_q.push_back(b);
      crc = crc_byte(crc, b);
    end
    if (last) begin
`ifdef ETH_TX_PAD_EN
      for (int i = len; i < 46; i++) begin
        exp_q.push_back(8'h00);
        crc = crc_byte(crc, 8'h00);
      end
`endif
      crc = ~crc;
      for (int k = 0; k < 4; k++) begin
        exp_q.push_back(crc[7:0]);
        crc = crc >> 8;
      end
    end
  endtask

  task automatic run_frame(input int len, input bit last, input logic [7:0] seed,
                           input int total, input bit exp_done, input bit exp_err,
                           input bit poke);
    logic [47:0]  d;
    logic [47:0]  s;
    logic [15:0]  t;
    int           g;
    d = {40'h0A1B2C3D4E, 8'(cur_case)};
    s = 48'h02005E102030 + 48'(seed);
    t = 16'h0800 + 16'(cur_case);
    en_cycles = 0;
    done_cnt  = 0;
    err_cnt   = 0;
    push_expect(len, last, seed, {d, s, t});
    @(negedge clk);
    bus.dest_addr = d;
    bus.src_addr  = s;
    bus.eth_type  = t;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.dest_addr = '1;
    bus.src_addr  = '1;
    bus.eth_type  = '1;
    check("start_busy", 32'(bus.busy), 1);
    check("start_en", 32'(bus.tx_en), 1);
    check("start_byte", 32'(bus.tx_out), 32'h55);
    for (int i = 0; i < len; i++) begin
      bus.pl_data  = seed + 8'(i);
      bus.pl_last  = last && (i == len - 1);
      bus.pl_valid = 1'b1;
      g = 0;
      while (!bus.pl_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (!bus.pl_ready) begin
        check("pl_ready_timeout", 32'(bus.pl_ready), 1);
        break;
      end
      @(negedge clk);
    end
    bus.pl_valid = 1'b0;
    bus.pl_last  = 1'b0;
    bus.pl_data  = 8'h00;
    if (poke) begin
      g = 0;
      while (done_cnt == 0 && g < 300) begin
        @(negedge clk);
        g++;
      end
      check("done_wait", 32'(done_cnt > 0), 1);
      repeat (2) @(negedge clk);
      bus.dest_addr = 48'hDEADBEEF0000;
      bus.start     = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    g = 0;
    while (bus.busy && g < 500) begin
      @(negedge clk);
      g++;
    end
    check("busy_timeout", 32'(bus.busy), 0);
    @(negedge clk);
    check("en_cycles", en_cycles, total);
    check("done_count", done_cnt, 32'(exp_done));
    check("err_count", err_cnt, 32'(exp_err));
    check("queue_empty", exp_q.size(), 0);
    if (exp_done) begin
      check("done_cycle", en_at_done, total);
      check("gap_after_done", fall_cyc - done_cyc, Ifg + 1);
    end
    if (exp_err) check("gap_after_err", fall_cyc - err_cyc, Ifg);
    exp_q.delete();
    if (poke) begin
      en_cycles = 0;
      repeat (30) @(negedge clk);
      check("gap_start_ignored", en_cycles, 0);
      check("gap_start_busy", 32'(bus.busy), 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{46, 1'b1, 8'h00, 72,    1'b1, 1'b0};
    vecs[1] = '{1,  1'b1, 8'hAB, Tot1,  1'b1, 1'b0};
    vecs[2] = '{10, 1'b0, 8'h30, 32,    1'b0, 1'b1};
    vecs[3] = '{65, 1'b0, 8'h80, 86,    1'b0, 1'b1};
    vecs[4] = '{64, 1'b1, 8'hC0, 90,    1'b1, 1'b0};
    vecs[5] = '{20, 1'b1, 8'h11, Tot20, 1'b1, 1'b0};
    vecs[6] = '{50, 1'b1, 8'hF0, 76,    1'b1, 1'b0};

    bus.start     = 1'b0;
    bus.dest_addr = '0;
    bus.src_addr  = '0;
    bus.eth_type  = '0;
    bus.pl_data   = '0;
    bus.pl_valid  = 1'b0;
    bus.pl_last   = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx_en", 32'(bus.tx_en), 0);
    check("rst_tx_out", 32'(bus.tx_out), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_pl_ready", 32'(bus.pl_ready), 0);
    check("rst_done_err", 32'({bus.tx_done, bus.tx_err}), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      cur_case = i;
      run_frame(vecs[i].len, vecs[i].last, vecs[i].seed, vecs[i].total,
                vecs[i].done, vecs[i].err, 1'b0);
    end

    // Reset while the source address is on the line.
    cur_case = 7;
    mon_en   = 1'b0;
    done_cnt = 0;
    err_cnt  = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    check("pre_rst_en", 32'(bus.tx_en), 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx_en", 32'(bus.tx_en), 0);
    check("midrst_tx_out", 32'(bus.tx_out), 0);
    check("midrst_busy", 32'(bus.busy), 0);
    check("midrst_pl_ready", 32'(bus.pl_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_no_pulse", done_cnt + err_cnt, 0);
    exp_q.delete();
    mon_en = 1'b1;
    run_frame(46, 1'b1, 8'h5A, 72, 1'b1, 1'b0, 1'b0);

    // Start request during the inter-frame gap must be dropped.
    cur_case = 8;
    run_frame(46, 1'b1, 8'h21, 72, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/eth_frame_tx.md
ETH_FRAME_TX -- requirements
Module: eth_frame_tx

Interface
REQ-001 SHALL provide parameter PREAMBLE_LEN, default 7, number of 0x55 preamble bytes (1..15).
REQ-002 SHALL provide parameter MAX_PAYLOAD, default 1500, maximum accepted payload bytes (46..9000).
REQ-003 SHALL provide parameter IFG_CYCLES, default 12, idle cycles forced after every frame or abort (0..255).
REQ-004 SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  frame request, sampled only when busy=0.
REQ-008 dest_addr  in  48  destination MAC, MSB byte first.
REQ-009 src_addr  in  48  source MAC, MSB byte first.
REQ-010 eth_type  in  16  EtherType/length, MSB byte first.
REQ-011 pl_data  in  8  payload byte.
REQ-012 pl_valid  in  1  pl_data valid.
REQ-013 pl_last  in  1  marks final payload byte.
REQ-014 pl_ready  out  1  byte accepted when pl_valid&pl_ready.
REQ-015 tx_out  out  8  line byte.
REQ-016 tx_en  out  1  tx_out valid.
REQ-017 tx_done  out  1  one-cycle pulse, frame complete.
REQ-018 tx_err  out  1  one-cycle pulse, frame aborted.
REQ-019 busy  out  1  high from accepted start until IFG ends.

Function
REQ-020 States SHALL be IDLE, PREAMBLE, SFD, DEST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG; all outputs registered.
REQ-021 start&!busy SHALL latch dest_addr, src_addr, eth_type and set busy next cycle; first 0x55 appears with tx_en=1 that same next cycle.
REQ-022 PREAMBLE SHALL emit PREAMBLE_LEN bytes 0x55, then SFD one byte 0xD5, then 6 DEST, 6 SRC, 2 TYPE bytes, tx_en=1 throughout.
REQ-023 PAYLOAD: pl_ready SHALL be high only in PAYLOAD; each accepted byte appears on tx_out the following cycle, one byte per cycle.
REQ-024 pl_valid=0 in PAYLOAD (underrun) SHALL abort: tx_en=0 next cycle, tx_err pulse, go to IFG, no tx_done.
REQ-025 Acceptance of byte number MAX_PAYLOAD+1 without prior pl_last SHALL abort as REQ-024; byte MAX_PAYLOAD with pl_last is legal.
REQ-026 After pl_last, go to PAD if enabled and count<46, else FCS.
REQ-027 FCS SHALL be IEEE 802.3 CRC-32 (reflected poly 0xEDB88320, init 0xFFFFFFFF, final inversion) over DEST through PAD, sent as 4 bytes least-significant byte first.
REQ-028 tx_done SHALL pulse in the cycle the last FCS byte is on tx_out; IFG follows.
REQ-029 IFG SHALL hold tx_en=0, tx_out=0x00, busy=1 for IFG_CYCLES cycles (0 = straight to IDLE); start ignored.
REQ-030 Payload byte counter SHALL be $clog2(MAX_PAYLOAD+2) bits, saturating, never wrapping.
REQ-031 tx_out SHALL be 0x00 whenever tx_en=0.

Reset
REQ-032 rst SHALL force IDLE immediately, with tx_out=0x00 and tx_en, tx_done, tx_err, busy, pl_ready=0, and clear CRC and counters.
REQ-033 rst mid-frame SHALL truncate without tx_err or tx_done; first start after release begins a full preamble.

Configuration
REQ-034 Macro ETH_TX_PAD_EN defined: payloads under 46 bytes SHALL be padded with 0x00 to 46 bytes, included in FCS.
REQ-035 Macro ETH_TX_PAD_EN undefined: PAD state absent; FCS follows last payload byte directly for any length >=1.

Verification
REQ-036 Defaults, 46-byte payload 0x00..0x2D, pl_valid held -> 72 tx_en cycles: 7x0x55, 0xD5, header, payload, FCS equal to software CRC-32 model, tx_done on cycle 72.
REQ-037 With ETH_TX_PAD_EN, 1-byte payload 0xAB -> 0xAB plus 45x0x00, FCS over padded data, 72 bytes; without macro -> 27 bytes total.
REQ-038 pl_valid dropped after 10 payload bytes -> tx_en low next cycle, tx_err=1 one cycle, busy low after 12 IFG cycles.
REQ-039 MAX_PAYLOAD=64, 65 bytes without pl_last -> abort on byte 65; 64 bytes with pl_last -> normal tx_done.
REQ-040 rst asserted in SRC state -> outputs zero same cycle; start 1 cycle after release -> full 7x0x55 preamble; start asserted during IFG -> ignored.
